// File: rtl/cp_if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests
// to instruction memory (req/gnt + rvalid), buffers returned words in a
// 2-entry queue and hands them to ID on a valid/ready handshake. A redirect
// restarts fetch at a new PC and squashes queued and in-flight words.
//
// Handshakes:
//   imem side : a request issues on a cycle with imem_req_o & imem_gnt_i.
//               imem_addr_o holds steady while imem_req_o waits for imem_gnt_i,
//               unless redirect_i moves it. Responses come back in issue order,
//               at least one cycle after their grant, one per imem_rvalid_i.
//   ID side   : a word transfers on a cycle with instr_valid_id_o &
//               instr_ready_id_i. While valid is high and ready is low,
//               instr_data_id_o and pc_id_o do not change.
module cp_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_data_id_o,
  output logic [31:0] pc_id_o,
  input  logic        instr_ready_id_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  logic [31:0] fetch_pc;
  logic [31:0] out_pc;
  logic [1:0]  inflight;
  logic [1:0]  discard;
  logic [1:0]  fifo_cnt;
  logic [31:0] fifo_q0;
  logic [31:0] fifo_q1;
  logic        started;

  logic        pop;
  logic [2:0]  occupancy;
  logic        credit;
  logic        issue;
  logic        resp;
  logic        drop;
  logic        push;
  logic [31:0] redir_pc;
  logic        unused_pc_bits;

  // Low address bits of the redirect target are forced to zero.
  assign redir_pc       = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Handshake qualifiers and the two-word credit rule.
  assign pop        = (fifo_cnt != 2'd0) & instr_ready_id_i;
  assign occupancy  = {1'b0, inflight} + {1'b0, fifo_cnt} - {2'b00, pop};
  assign credit     = (occupancy < 3'd2);
  assign imem_req_o = started & credit & ~redirect_i;
  assign imem_addr_o = fetch_pc;
  assign issue      = imem_req_o & imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp       = imem_rvalid_i & (inflight != 2'd0);
  assign drop       = resp & (discard != 2'd0);
  assign push       = resp & ~drop & ~redirect_i;

  assign instr_valid_id_o = (fifo_cnt != 2'd0);
  assign instr_data_id_o  = fifo_q0;
  assign pc_id_o          = out_pc;

  // Start fetching one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  // Fetch PC advances on issue; output PC advances on pop; both reload on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      out_pc   <= RESET_PC;
    end else begin
      if (redirect_i) begin
        fetch_pc <= redir_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (redirect_i) begin
        out_pc <= redir_pc;
      end else if (pop) begin
        out_pc <= out_pc + 32'd4;
      end
    end
  end

  // Outstanding-request and stale-response counters.
  // discard never exceeds inflight (stale words are a subset of those in
  // flight), so on redirect every request still outstanding after this
  // cycle's response becomes stale: the new discard is inflight minus resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 2'd0;
      discard  <= 2'd0;
    end else begin
      inflight <= inflight + {1'b0, issue} - {1'b0, resp};
      if (redirect_i) begin
        discard <= inflight - {1'b0, resp};
      end else if (drop) begin
        discard <= discard - 2'd1;
      end
    end
  end

  // Two-entry in-order queue; fifo_q0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt <= 2'd0;
      fifo_q0  <= 32'd0;
      fifo_q1  <= 32'd0;
    end else if (redirect_i) begin
      fifo_cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            fifo_q0 <= imem_rdata_i;
          end else begin
            fifo_q1 <= imem_rdata_i;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_q0  <= fifo_q1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_q0 <= imem_rdata_i;
          end else begin
            fifo_q0 <= fifo_q1;
            fifo_q1 <= imem_rdata_i;
          end
        end
        default: begin
          fifo_cnt <= fifo_cnt;
        end
      endcase
    end
  end

  // The credit rule keeps a push off a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_cnt == 2'd2));

  // Memory must not return a word that was never requested.
  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid_i && inflight == 2'd0));

endmodule

// File: tb/tb_cp_if_stage.sv
// Directed bench for cp_if_stage: a queued in-order memory model with
// programmable latency, a transfer monitor, and hand-computed expectations.
module tb_cp_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_id_o;
  logic [31:0] instr_data_id_o;
  logic [31:0] pc_id_o;
  logic        instr_ready_id_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  logic        req2;
  logic [31:0] addr2;
  logic        gnt2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        valid2;
  logic [31:0] data2;
  logic [31:0] pc2;
  logic        ready2;
  logic        redir2;
  logic [31:0] rpc2;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int lat      = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  mem_t        mq[$];
  logic [31:0] issue_q[$];
  int          iss_cyc[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  logic [31:0] iss2_q[$];
  logic [31:0] obs2_pc[$];
  logic [31:0] obs2_data[$];
  logic [31:0] exp_q[$];
  logic        pend2;
  logic [31:0] pend2_addr;

  cp_if_stage u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .instr_valid_id_o (instr_valid_id_o),
    .instr_data_id_o  (instr_data_id_o),
    .pc_id_o          (pc_id_o),
    .instr_ready_id_i (instr_ready_id_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i)
  );

  cp_if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_o       (req2),
    .imem_addr_o      (addr2),
    .imem_gnt_i       (gnt2),
    .imem_rvalid_i    (rvalid2),
    .imem_rdata_i     (rdata2),
    .instr_valid_id_o (valid2),
    .instr_data_id_o  (data2),
    .pc_id_o          (pc2),
    .instr_ready_id_i (ready2),
    .redirect_i       (redir2),
    .redirect_pc_i    (rpc2)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory contents: each word is its address with the top half scrambled.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    issue_q.delete(); iss_cyc.delete();
    obs_pc.delete(); obs_data.delete(); obs_cyc.delete();
    iss2_q.delete(); obs2_pc.delete(); obs2_data.delete();
    chk("rst_req",   {31'd0, imem_req_o},       32'd0);
    chk("rst_addr",  imem_addr_o,               32'h0000_0000);
    chk("rst_valid", {31'd0, instr_valid_id_o}, 32'd0);
    chk("rst_data",  instr_data_id_o,           32'd0);
    chk("rst_pc",    pc_id_o,                   32'h0000_0000);
    chk("rst_pc2",   pc2,                       32'hFFFF_FFF8);
    imem_gnt_i = 1'b1; instr_ready_id_i = 1'b1; redirect_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Memory model and monitor: drive responses at the falling edge, sample
  // handshakes 3 time units later, well before the next rising edge.
  initial begin
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    rvalid2 = 1'b0; rdata2 = 32'd0; pend2 = 1'b0; pend2_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        cyc = 0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
        rvalid2 = 1'b0; rdata2 = 32'd0; pend2 = 1'b0;
      end else begin
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(mq[0].addr);
        end else begin
          imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
        end
        rvalid2 = pend2;
        rdata2  = pend2 ? mem_word(pend2_addr) : 32'd0;
        #3;
        if (rst_n) begin
          if (imem_rvalid_i) mq.pop_front();
          if (imem_req_o && imem_gnt_i) begin
            mq.push_back('{addr: imem_addr_o, due: cyc + lat});
            issue_q.push_back(imem_addr_o);
            iss_cyc.push_back(cyc);
          end
          if (instr_valid_id_o && instr_ready_id_i) begin
            obs_pc.push_back(pc_id_o);
            obs_data.push_back(instr_data_id_o);
            obs_cyc.push_back(cyc);
          end
          pend2      = req2 & gnt2;
          pend2_addr = addr2;
          if (req2 && gnt2) iss2_q.push_back(addr2);
          if (valid2 && ready2) begin
            obs2_pc.push_back(pc2);
            obs2_data.push_back(data2);
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus and checks.
  initial begin
    logic [31:0] hold_addr;
    logic [31:0] got;
    int n0;
    int ni;
    int bad;
    int budget;

    imem_gnt_i = 1'b1; instr_ready_id_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    gnt2 = 1'b1; ready2 = 1'b1; redir2 = 1'b0; rpc2 = 32'd0;
    #2;
    apply_reset();

    // Back-to-back stream with a 1-cycle memory.
    repeat (8) step();
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    chk("s1_nobs", {31'd0, obs_pc.size() >= 4}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      got = (i < issue_q.size()) ? issue_q[i] : 32'hDEAD_BEEF;
      chk("s1_iss_addr", got, exp_q[i]);
      got = (i < obs_pc.size()) ? obs_pc[i] : 32'hDEAD_BEEF;
      chk("s1_pc", got, exp_q[i]);
      got = (i < obs_data.size()) ? obs_data[i] : 32'hDEAD_BEEF;
      chk("s1_data", got, mem_word(exp_q[i]));
    end
    chk("s1_latency", 32'(obs_cyc.size() > 0 ? obs_cyc[0] - iss_cyc[0] : -1), 32'd2);
    chk("s1_rate", 32'(obs_cyc.size() > 3 ? obs_cyc[3] - obs_cyc[0] : -1), 32'd3);

    // ID stalled for 10 cycles.
    instr_ready_id_i = 1'b0;
    repeat (10) step();
    chk("stall_req",   {31'd0, imem_req_o},       32'd0);
    chk("stall_valid", {31'd0, instr_valid_id_o}, 32'd1);
    chk("stall_pc",    pc_id_o,                   32'(4 * obs_pc.size()));
    chk("stall_data",  instr_data_id_o,           mem_word(32'(4 * obs_pc.size())));
    chk("stall_held",  32'(issue_q.size() - obs_pc.size()), 32'd2);
    instr_ready_id_i = 1'b1;
    repeat (8) step();
    bad = 0;
    for (int i = 0; i < obs_pc.size(); i++) begin
      if (obs_pc[i] !== 32'(4 * i) || obs_data[i] !== mem_word(32'(4 * i))) bad++;
    end
    chk("resume_seq", 32'(bad), 32'd0);
    chk("resume_len", {31'd0, obs_pc.size() >= 12}, 32'd1);

    // Grant withheld for 3 cycles.
    hold_addr = 32'(4 * issue_q.size());
    ni = issue_q.size();
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nogt_req",  {31'd0, imem_req_o}, 32'd1);
      chk("nogt_addr", imem_addr_o,         hold_addr);
      step();
    end
    chk("nogt_noiss", 32'(issue_q.size()), 32'(ni));
    imem_gnt_i = 1'b1;
    step(); step();
    got = (ni < issue_q.size()) ? issue_q[ni] : 32'hDEAD_BEEF;
    chk("nogt_issue", got, hold_addr);

    // Reset mid-stream, then redirect with two requests in flight, latency 3.
    lat = 3;
    apply_reset();
    budget = 10;
    step();
    while (issue_q.size() < 2 && budget > 0) begin
      step();
      budget--;
    end
    chk("rd_two_inflight", 32'(issue_q.size()), 32'd2);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    #1;
    chk("rd_req_low", {31'd0, imem_req_o}, 32'd0);
    step();
    redirect_i = 1'b0;
    repeat (14) step();
    got = (obs_pc.size() > 0) ? obs_pc[0] : 32'hDEAD_BEEF;
    chk("rd_first_pc", got, 32'h0000_0100);
    got = (obs_data.size() > 0) ? obs_data[0] : 32'hDEAD_BEEF;
    chk("rd_first_data", got, 32'hC0DE_0100);
    got = (obs_pc.size() > 1) ? obs_pc[1] : 32'hDEAD_BEEF;
    chk("rd_second_pc", got, 32'h0000_0104);
    got = (issue_q.size() > 2) ? issue_q[2] : 32'hDEAD_BEEF;
    chk("rd_new_addr", got, 32'h0000_0100);

    // Redirect coinciding with a pop and a response, target 0x203.
    lat = 1;
    apply_reset();
    repeat (8) step();
    n0 = obs_pc.size();
    ni = issue_q.size();
    chk("rp_rvalid", {31'd0, imem_rvalid_i & instr_valid_id_o}, 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203;
    #1;
    chk("rp_req_low", {31'd0, imem_req_o}, 32'd0);
    step();
    redirect_i = 1'b0;
    repeat (8) step();
    got = (n0 < obs_pc.size()) ? obs_pc[n0] : 32'hDEAD_BEEF;
    chk("rp_popped_pc", got, 32'(4 * n0));
    got = (n0 + 1 < obs_pc.size()) ? obs_pc[n0 + 1] : 32'hDEAD_BEEF;
    chk("rp_next_pc", got, 32'h0000_0200);
    got = (n0 + 1 < obs_data.size()) ? obs_data[n0 + 1] : 32'hDEAD_BEEF;
    chk("rp_next_data", got, 32'hC0DE_0200);
    got = (ni < issue_q.size()) ? issue_q[ni] : 32'hDEAD_BEEF;
    chk("rp_next_addr", got, 32'h0000_0200);

    // Wrap-around instance started at 0xFFFF_FFF8.
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      got = (i < iss2_q.size()) ? iss2_q[i] : 32'hDEAD_BEEF;
      chk("wrap_addr", got, exp_q[i]);
      got = (i < obs2_pc.size()) ? obs2_pc[i] : 32'hDEAD_BEEF;
      chk("wrap_pc", got, exp_q[i]);
    end
    got = (obs2_data.size() > 1) ? obs2_data[1] : 32'hDEAD_BEEF;
    chk("wrap_data1", got, 32'h3F21_FFFC);
    got = (obs2_data.size() > 2) ? obs2_data[2] : 32'hDEAD_BEEF;
    chk("wrap_data2", got, 32'hC0DE_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
